display_driver: RTL and testbench



---
 rtl/display_pkg.sv | 44 ++++
 rtl/display_driver_bin2bcd.sv | 25 ++
 rtl/display_driver.sv | 92 +++++++++
 tb/tb_display_driver.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, BCD struct and segment encoder for the 4-digit display driver.
package display_pkg;

    localparam int DIGITS = 4;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd3_t;

    // Active-low pattern for a BCD nibble; anything above 9 is shown blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_driver_bin2bcd.sv
// Combinational 8-bit binary to 3-digit BCD converter (double dabble).
module bin2bcd
    import display_pkg::*;
(
    input  logic [7:0] bin,
    output bcd3_t      bcd
);

    logic [19:0] shift_next;

    always_comb begin
        shift_next = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (shift_next[19:16] >= 4'd5) shift_next[19:16] = shift_next[19:16] + 4'd3;
            if (shift_next[15:12] >= 4'd5) shift_next[15:12] = shift_next[15:12] + 4'd3;
            if (shift_next[11:8]  >= 4'd5) shift_next[11:8]  = shift_next[11:8]  + 4'd3;
            shift_next = {shift_next[18:0], 1'b0};
        end
    end

    assign bcd.hundreds = shift_next[19:16];
    assign bcd.tens     = shift_next[15:12];
    assign bcd.ones     = shift_next[11:8];

endmodule

// File: rtl/display_driver.sv
// OUT register plus multiplexed 4-digit seven-segment decimal display.
// Define DISPLAY_SIGNED_EN to show the latched byte as a signed two's-complement value.
module display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        cpu_clk,
    input  logic        enable,
    input  logic [7:0]  bus,
    output logic [7:0]  segments,
    output logic [3:0]  digit
);

    localparam int                 CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic               cpu_clk_q_reg;
    logic               cpu_edge;
    logic [7:0]         value_reg;
    logic [CNT_W-1:0]   scan_cnt_reg;
    logic [1:0]         sel_reg;
    logic [7:0]         segments_reg, segments_next;
    logic [DIGITS-1:0]  digit_reg, digit_next;
    logic [7:0]         magnitude;
    logic               negative;
    bcd3_t              bcd;

    // cpu_clk is only ever sampled as data; a held-high level yields one edge.
    assign cpu_edge = cpu_clk & ~cpu_clk_q_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cpu_clk_q_reg <= 1'b0;
            value_reg     <= 8'd0;
            scan_cnt_reg  <= '0;
            sel_reg       <= 2'd0;
            segments_reg  <= SEG_0;
            digit_reg     <= 4'b1110;
        end else begin
            cpu_clk_q_reg <= cpu_clk;
            if (cpu_edge && enable)
                value_reg <= bus;
            if (scan_cnt_reg == CNT_LAST) begin
                scan_cnt_reg <= '0;
                sel_reg      <= sel_reg + 2'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + 1'b1;
            end
            segments_reg <= segments_next;
            digit_reg    <= digit_next;
        end
    end

`ifdef DISPLAY_SIGNED_EN
    // Negating 8'h80 gives 8'h80 back, which reads as 128 unsigned: "-128".
    assign negative  = value_reg[7];
    assign magnitude = value_reg[7] ? (~value_reg + 8'd1) : value_reg;
`else
    assign negative  = 1'b0;
    assign magnitude = value_reg;
`endif

    bin2bcd u_bin2bcd (
        .bin (magnitude),
        .bcd (bcd)
    );

    always_comb begin
        segments_next = SEG_BLANK;
        case (sel_reg)
            2'd0: segments_next = seg_encode(bcd.ones);
            2'd1: if (bcd.hundreds != 4'd0 || bcd.tens != 4'd0)
                      segments_next = seg_encode(bcd.tens);
            2'd2: if (bcd.hundreds != 4'd0)
                      segments_next = seg_encode(bcd.hundreds);
            2'd3: if (negative)
                      segments_next = SEG_MINUS;
            default: segments_next = SEG_BLANK;
        endcase
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_anode
        assign digit_next[gi] = (sel_reg != 2'(gi));
    end

    assign segments = segments_reg;
    assign digit    = digit_reg;

endmodule

// File: tb/tb_display_driver.sv
// Directed self-checking bench for display_driver with REFRESH_DIV=4.
module tb_display_driver;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       cpu_clk = 1'b0;
    logic       enable  = 1'b0;
    logic [7:0] bus     = 8'd0;
    logic [7:0] segments;
    logic [3:0] digit;

    int checks   = 0;
    int failures = 0;

    display_driver #(.REFRESH_DIV(4)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .cpu_clk  (cpu_clk),
        .enable   (enable),
        .bus      (bus),
        .segments (segments),
        .digit    (digit)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic cpu_pulse(input logic [7:0] b, input logic en);
        bus    = b;
        enable = en;
        @(negedge sys_clk);
        cpu_clk = 1'b1;
        cycles(2);
        cpu_clk = 1'b0;
        cycles(2);
    endtask

    // Waits (bounded) for digit k to be selected, then checks its segments.
    task automatic check_digit(input int k, input logic [7:0] exp_seg, input string tag);
        logic [3:0] want;
        int n;
        want = ~(4'b0001 << k);
        n = 0;
        while (digit !== want && n < 40) begin
            @(negedge sys_clk);
            n++;
        end
        checks++;
        assert (digit === want) else begin
            failures++;
            $error("FAIL %s_sel digit=%b expected=%b", tag, digit, want);
        end
        checks++;
        assert (segments === exp_seg) else begin
            failures++;
            $error("FAIL %s_d%0d segments=%h expected=%h", tag, k, segments, exp_seg);
        end
        $display("check %s digit%0d segments=%h expected=%h", tag, k, segments, exp_seg);
    endtask

    task automatic check_display(input logic [7:0] d3, input logic [7:0] d2,
                                 input logic [7:0] d1, input logic [7:0] d0,
                                 input string tag);
        cycles(16);
        check_digit(0, d0, tag);
        check_digit(1, d1, tag);
        check_digit(2, d2, tag);
        check_digit(3, d3, tag);
    endtask

    initial begin
        logic [3:0] exp_digit;
        logic [7:0] exp_seg;

        // Reset for 2 cycles; outputs must show the reset pattern.
        cycles(2);
        checks++;
        assert (digit === 4'b1110) else begin
            failures++;
            $error("FAIL reset_digit digit=%b expected=1110", digit);
        end
        checks++;
        assert (segments === 8'hC0) else begin
            failures++;
            $error("FAIL reset_seg segments=%h expected=c0", segments);
        end
        $display("check reset digit=%b segments=%h", digit, segments);

        // Scan walks each digit for 4 cycles; value 0 shows only the ones digit.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            exp_digit = ~(4'b0001 << (i / 4));
            exp_seg   = (i < 4) ? 8'hC0 : 8'hFF;
            checks++;
            assert (digit === exp_digit) else begin
                failures++;
                $error("FAIL scan_digit cycle=%0d digit=%b expected=%b", i, digit, exp_digit);
            end
            checks++;
            assert (segments === exp_seg) else begin
                failures++;
                $error("FAIL scan_seg cycle=%0d segments=%h expected=%h", i, segments, exp_seg);
            end
        end
        $display("check scan sequence done");

        cpu_pulse(8'd123, 1'b1);
        check_display(8'hFF, 8'hF9, 8'hA4, 8'hB0, "cap123");

        for (int i = 0; i < 3; i++) cpu_pulse(8'd45, 1'b0);
        check_display(8'hFF, 8'hF9, 8'hA4, 8'hB0, "enable_low");

        cpu_pulse(8'd7, 1'b1);
        check_display(8'hFF, 8'hFF, 8'hFF, 8'hF8, "cap7");

        cpu_pulse(8'd255, 1'b1);
        check_display(8'hFF, 8'hA4, 8'h92, 8'h92, "cap255");

        cpu_pulse(8'd100, 1'b1);
        check_display(8'hFF, 8'hF9, 8'hC0, 8'hC0, "cap100");

        // Held cpu_clk: only the value present at the rising edge is taken.
        bus    = 8'd10;
        enable = 1'b1;
        @(negedge sys_clk);
        cpu_clk = 1'b1;
        cycles(2);
        bus = 8'd20;
        cycles(6);
        cpu_clk = 1'b0;
        cycles(2);
        check_display(8'hFF, 8'hFF, 8'hF9, 8'hC0, "held");

`ifdef DISPLAY_SIGNED_EN
        cpu_pulse(8'hFB, 1'b1);
        check_display(8'hBF, 8'hFF, 8'hFF, 8'h92, "neg5");
        cpu_pulse(8'h80, 1'b1);
        check_display(8'hBF, 8'hF9, 8'hA4, 8'h80, "neg128");
        cpu_pulse(8'h7F, 1'b1);
        check_display(8'hFF, 8'hF9, 8'hA4, 8'hF8, "pos127");
`else
        cpu_pulse(8'hFB, 1'b1);
        check_display(8'hFF, 8'hA4, 8'h92, 8'hF9, "cap251");
`endif

        // Reset mid-scan must restore value 0 and digit 0.
        cycles(5);
        rst = 1'b1;
        cycles(1);
        checks++;
        assert (digit === 4'b1110) else begin
            failures++;
            $error("FAIL midreset_digit digit=%b expected=1110", digit);
        end
        checks++;
        assert (segments === 8'hC0) else begin
            failures++;
            $error("FAIL midreset_seg segments=%h expected=c0", segments);
        end
        $display("check midreset digit=%b segments=%h", digit, segments);
        rst = 1'b0;
        check_display(8'hFF, 8'hFF, 8'hFF, 8'hC0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
